square_unit: RTL and testbench
==============================

SQUARE_UNIT -- requirements
Module: square_unit

Interface
REQ-001 Parameter N, default 4: operand width in bits; legal range 2..16.
REQ-002 Parameter OUT_W, default 2*N: result width in bits; legal range N..2*N.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 n  input  N  operand.
REQ-009 sign  input  1  1 = n is two's-complement signed; 0 = n is unsigned.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 square  output  OUT_W  result: n squared.
REQ-013 ovf  output  1  true square did not fit in OUT_W bits; valid while out_valid=1.

Function
REQ-014 The FSM SHALL have exactly three states:
- IDLE: in_ready=1, out_valid=0.
- CALC: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-015 An accept (in_valid=1 and in_ready=1 at a rising edge) SHALL capture n and sign, and move IDLE->CALC.
REQ-016 On accept, the magnitude SHALL be computed as follows:
- If sign=1 and n[N-1]=1: magnitude = two's-complement negation of n, as an unsigned N-bit value, so the most negative value maps to 2^(N-1).
- Otherwise: magnitude = n.
REQ-017 In CALC, the block SHALL perform one shift-add step per cycle over the magnitude bits, LSB first, using a 2*N-bit accumulator.
REQ-018 The block SHALL take exactly N cycles in CALC: out_valid rises on the Nth rising edge after the accepting edge.
REQ-019 The exact square SHALL be computed at full 2*N-bit width; no intermediate truncation is allowed.
REQ-020 square and ovf SHALL be registered, and SHALL be held stable for the whole time out_valid=1.
REQ-021 DONE->IDLE SHALL occur on the edge where out_ready=1; out_valid=1 SHALL persist indefinitely while out_ready=0.
REQ-022 in_valid asserted outside IDLE SHALL be ignored; changes to n or sign outside the accept edge SHALL have no effect.
REQ-023 When OUT_W=2*N, ovf SHALL be constant 0.
REQ-024 When OUT_W<2*N, ovf SHALL be 1 iff the exact square >= 2^OUT_W.
REQ-025 After an accept, a new operand SHALL be accepted no earlier than the edge following the DONE->IDLE transition (no back-to-back overlap).

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL set the following, regardless of current state:
- state = IDLE
- out_valid = 0
- square = 0
- ovf = 0
- accumulator = 0
- captured operand = 0
REQ-027 in_ready SHALL be 0 while rst=1, and 1 on the first cycle after rst deasserts.
REQ-028 Reset during CALC or DONE SHALL discard the operation in progress; no result SHALL be presented for it.
REQ-029 rst SHALL take priority over a simultaneous accept or out_ready.

Configuration
REQ-030 The macro SQUARE_SAT_EN SHALL select the overflow behaviour:
- Defined: on overflow, square = all ones in OUT_W bits.
- Not defined: on overflow, square = exact square modulo 2^OUT_W (low OUT_W bits).
REQ-031 ovf behaviour SHALL be identical with and without SQUARE_SAT_EN.

Verification
REQ-032 N=4, sign=0, n=15, out_ready=1 -> out_valid on 4th edge after accept; square=225; ovf=0.
REQ-033 N=4, sign=1, operand sweep:
- n=4'b1000 -> square=64.
- n=4'b1001 -> square=49.
- n=4'b1111 -> square=1.
- n=0 -> square=0.
REQ-034 Back-pressure: out_ready=0 for 10 cycles after out_valid -> square, ovf and out_valid held constant; in_valid pulses ignored; accept possible only after DONE->IDLE.
REQ-035 Reset mid-operation: rst=1 on 2nd CALC cycle -> all outputs 0 next cycle; no out_valid appears for the discarded operand; next operand n=3 unsigned -> square=9.
REQ-036 N=4, OUT_W=6, sign=0, n=15:
- SQUARE_SAT_EN undefined -> square=33, ovf=1.
- SQUARE_SAT_EN defined -> square=63, ovf=1.
- n=7 in either build -> square=49, ovf=0.
REQ-037 Exhaustive sweep, N=4 and N=8, both sign values, random out_ready -> every result matches a reference square; no result lost or duplicated.

Source files
------------

// File: rtl/square_unit.sv
// square_unit: sequential squarer using an LSB-first shift-add multiplier.
// A valid/ready operand (signed or unsigned) is captured in IDLE, its
// magnitude is squared over exactly N CALC cycles into a 2*N-bit
// accumulator, and the registered result is held in DONE until the
// consumer takes it.
// Optional feature: define SQUARE_SAT_EN to saturate `square` to all
// ones when the exact square does not fit in OUT_W bits. Without it,
// `square` carries the low OUT_W bits. `ovf` behaves the same in both
// builds.
module square_unit #(
  parameter int N     = 4,
  parameter int OUT_W = 2 * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     n,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] square,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t             state_q;
  logic [N-1:0]       mult_q;     // multiplier bits still to consume, LSB first
  logic [2*N-1:0]     mcand_q;    // multiplicand, shifted left once per step
  logic [2*N-1:0]     acc_q;      // running partial product, full width
  logic [CNT_W-1:0]   cnt_q;      // steps already performed in CALC
  logic [OUT_W-1:0]   square_q;
  logic               ovf_q;

  logic [N-1:0]       mag_d;
  logic [2*N-1:0]     acc_d;
  logic [OUT_W-1:0]   square_d;
  logic               ovf_d;

  // Magnitude of the offered operand; the most negative signed value maps
  // to 2^(N-1), which still fits in N unsigned bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    mag_d = n;
    if (sign && n[N-1]) begin
      mag_d = ~n + N'(1);
    end
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set. The accumulator is never truncated.
  always_comb begin
    acc_d = acc_q;
    if (mult_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Overflow means any bit of the exact square lies above OUT_W.
  if (OUT_W == 2 * N) begin : g_full_width
    assign ovf_d = 1'b0;
  end else begin : g_narrow
    assign ovf_d = |acc_d[2*N-1:OUT_W];
  end

  // Result presented to the consumer, either wrapped or saturated.
  always_comb begin
    square_d = acc_d[OUT_W-1:0];
`ifdef SQUARE_SAT_EN
    if (ovf_d) begin
      square_d = '1;
    end
`endif
  end

  // Control FSM and datapath registers; results are loaded on the last
  // CALC step so they stay stable for the whole DONE state.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    if (rst) begin
      // NOTE: the whole datapath is cleared, not just the state, so a
      // discarded operation leaves nothing behind on the outputs.
      state_q  <= IDLE;
      mult_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      square_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mult_q  <= mag_d;
            mcand_q <= {{N{1'b0}}, mag_d};
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mult_q  <= mult_q >> 1;
          mcand_q <= mcand_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            square_q <= square_d;
            ovf_q    <= ovf_d;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset so nothing looks acceptable while rst is high.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign square    = square_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_square_unit.sv
// tb_square_unit: drives three square_unit configurations (N=4/OUT_W=8,
// N=8/OUT_W=16, N=4/OUT_W=6) and compares each result with an arithmetic
// reference square computed in the bench.
module tb_square_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] iv;
  logic [2:0] ordy;
  logic [7:0] n_drv;
  logic       sg_drv;

  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic [2:0]  of;
  logic [7:0]  sq_a;
  logic [15:0] sq_b;
  logic [5:0]  sq_c;

  int          cur;
  logic        o_rdy;
  logic        o_ov;
  logic        o_of;
  logic [15:0] o_sq;

  int n_checks = 0;
  int n_err    = 0;

  square_unit #(.N(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
    .n(n_drv[3:0]), .sign(sg_drv), .out_valid(ov[0]), .out_ready(ordy[0]),
    .square(sq_a), .ovf(of[0])
  );

  square_unit #(.N(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
    .n(n_drv), .sign(sg_drv), .out_valid(ov[1]), .out_ready(ordy[1]),
    .square(sq_b), .ovf(of[1])
  );

  square_unit #(.N(4), .OUT_W(6)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
    .n(n_drv[3:0]), .sign(sg_drv), .out_valid(ov[2]), .out_ready(ordy[2]),
    .square(sq_c), .ovf(of[2])
  );

  // Observation view of the instance currently under test.
  always_comb begin
    o_rdy = rdy[0];
    o_ov  = ov[0];
    o_of  = of[0];
    o_sq  = {8'd0, sq_a};
    case (cur)
      1: begin o_rdy = rdy[1]; o_ov = ov[1]; o_of = of[1]; o_sq = sq_b; end
      2: begin o_rdy = rdy[2]; o_ov = ov[2]; o_of = of[2]; o_sq = {10'd0, sq_c}; end
      default: ;
    endcase
  end

  function automatic int nw(input int sel);
    return (sel == 1) ? 8 : 4;
  endfunction

  function automatic int ow(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 6;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: interpret the operand, square it as an integer, then apply
  // the output width rules.
  task automatic model(input int sel, input int nval, input bit sg,
                       output int esq, output int eof);
    int w   = nw(sel);
    int owd = ow(sel);
    int v   = nval & ((1 << w) - 1);
    int mag;
    int ex;
    if (sg && v >= (1 << (w - 1))) mag = (1 << w) - v;
    else                           mag = v;
    ex  = mag * mag;
    eof = (ex >= (1 << owd)) ? 1 : 0;
    esq = ex % (1 << owd);
`ifdef SQUARE_SAT_EN
    if (eof == 1) esq = (1 << owd) - 1;
`endif
  endtask

  // One full transaction: accept, count latency, check result, optionally
  // hold the result under back-pressure with ignored in_valid pulses.
  task automatic do_op(input int sel, input int nval, input bit sg, input int hold);
    int esq;
    int eof;
    int lat;
    model(sel, nval, sg, esq, eof);
    cur = sel;
    #1;
    lat = 0;
    while (!o_rdy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("ready_before_accept", 32'(o_rdy), 32'd1);
    n_drv      = 8'(nval);
    sg_drv     = sg;
    iv[sel]    = 1'b1;
    ordy[sel]  = (hold == 0);
    @(negedge clk);
    iv[sel] = 1'b0;
    n_drv   = 8'($urandom);
    sg_drv  = 1'($urandom);
    check("busy_in_calc", 32'(o_rdy), 32'd0);
    lat = 0;
    while (!o_ov && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(nw(sel)));
    check("square", 32'(o_sq), 32'(esq));
    check("ovf", 32'(o_of), 32'(eof));
    for (int i = 0; i < hold; i++) begin
      iv[sel] = 1'($urandom);
      n_drv   = 8'($urandom);
      sg_drv  = 1'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(o_ov), 32'd1);
      check("hold_square", 32'(o_sq), 32'(esq));
      check("hold_ovf", 32'(o_of), 32'(eof));
      check("hold_not_ready", 32'(o_rdy), 32'd0);
    end
    iv[sel]   = 1'b0;
    ordy[sel] = 1'b1;
    if (hold > 0) @(negedge clk);
    else          @(negedge clk);
    check("released_valid", 32'(o_ov), 32'd0);
    check("released_ready", 32'(o_rdy), 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    iv     = '0;
    ordy   = '0;
    n_drv  = '0;
    sg_drv = 1'b0;
    cur    = 0;
    repeat (2) @(negedge clk);

    // Reset state on every instance.
    for (int s = 0; s < 3; s++) begin
      cur = s;
      #1;
      check("rst_ready", 32'(o_rdy), 32'd0);
      check("rst_valid", 32'(o_ov), 32'd0);
      check("rst_square", 32'(o_sq), 32'd0);
      check("rst_ovf", 32'(o_of), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      cur = s;
      #1;
      check("post_rst_ready", 32'(o_rdy), 32'd1);
    end

    // Directed cases.
    do_op(0, 15, 1'b0, 0);     // 225, latency 4
    do_op(0, 8, 1'b1, 1);      // 64
    do_op(0, 9, 1'b1, 0);      // 49
    do_op(0, 15, 1'b1, 2);     // 1
    do_op(0, 0, 1'b1, 0);      // 0
    do_op(0, 13, 1'b0, 10);    // back-pressure for 10 cycles
    do_op(2, 15, 1'b0, 0);     // narrow output, overflow
    do_op(2, 7, 1'b0, 1);      // narrow output, fits
    do_op(1, 128, 1'b1, 0);    // most negative 8-bit value

    // Reset on the second CALC cycle discards the operation.
    cur = 0;
    #1;
    n_drv  = 8'd5;
    sg_drv = 1'b0;
    iv[0]  = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(o_rdy), 32'd0);
    @(negedge clk);
    check("mid_rst_valid", 32'(o_ov), 32'd0);
    check("mid_rst_square", 32'(o_sq), 32'd0);
    check("mid_rst_ovf", 32'(o_of), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("discarded_no_valid", 32'(o_ov), 32'd0);
    end
    do_op(0, 3, 1'b0, 0);      // 9

    // Exhaustive sweeps with random back-pressure.
    for (int sg = 0; sg < 2; sg++) begin
      for (int v = 0; v < 16; v++) begin
        do_op(0, v, 1'(sg), int'($urandom_range(0, 2)));
        do_op(2, v, 1'(sg), int'($urandom_range(0, 2)));
      end
      for (int v = 0; v < 256; v++) begin
        do_op(1, v, 1'(sg), int'($urandom_range(0, 2)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
